credit_arbiter: RTL and testbench

- Wormhole output-port allocator for one router output: shares the output crossbar column among the five input ports N, E, W, S, L.
- Replaces the RTS/DCTS per-flit handshake with credit-based flow control toward the downstream input buffer.
- Grant is held from head flit to tail flit; round-robin fairness between packets.
- Drives the crossbar select one-hot and the per-input grant lines.

---
 rtl/noc_pkg.sv | 31 +++
 rtl/credit_counter.sv | 52 +++++
 rtl/credit_arbiter.sv | 85 ++++++++
 tb/tb_credit_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the router output-port allocator: port numbering,
// arbiter states and the round-robin winner picker.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  localparam int P_N = 0;
  localparam int P_E = 1;
  localparam int P_W = 2;
  localparam int P_S = 3;
  localparam int P_L = 4;

  typedef logic [NUM_PORTS-1:0] port_vec_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // One-hot winner: first requester at or above the one-hot pointer,
  // wrapping to the lowest requester when nothing above the pointer asks.
  function automatic port_vec_t rr_pick(input port_vec_t req, input port_vec_t ptr);
    port_vec_t hi;
    hi = req & ~(ptr - NUM_PORTS'(1));
    if (hi != '0) begin
      return hi & (~hi + NUM_PORTS'(1));
    end
    return req & (~req + NUM_PORTS'(1));
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Downstream buffer credit tracker: one credit per free slot, with a sticky
// error flag when more credits come back than were ever handed out.
module credit_counter
  import noc_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // dec only arrives with a grant, which already requires a nonzero count.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({inc, dec})
      2'b01: cnt_d = cnt_q - 1'b1;
      2'b10: begin
        if (cnt_q == CNT_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= CNT_MAX;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt = cnt_q;
  assign err = err_q;

endmodule

// File: rtl/credit_arbiter.sv
// Wormhole output-port allocator: locks the crossbar column to one input from
// head to tail flit, round-robin between packets, credit flow control downstream.
module credit_arbiter
  import noc_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] tail,
  input  logic                 credit_in,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] xbar_sel,
  output logic                 flit_valid,
  output logic [CNT_W-1:0]     credit_cnt,
  output logic                 credit_err
);

  localparam port_vec_t PTR_RST = NUM_PORTS'(1 << P_L);

  arb_state_t state_q, state_d;
  port_vec_t  owner_q, owner_d;
  port_vec_t  rr_ptr_q, rr_ptr_d;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant    = '0;
    xbar_sel = '0;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          owner_d = rr_pick(req, rr_ptr_q);
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        xbar_sel = owner_q;
        if (credit_cnt != '0) begin
          grant = owner_q & req;
        end
        // Tail leaves via IDLE, so packets are separated by one bubble cycle.
        if ((grant & tail) != '0) begin
          state_d  = IDLE;
          rr_ptr_d = {owner_q[NUM_PORTS-2:0], owner_q[NUM_PORTS-1]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= PTR_RST;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign flit_valid = |grant;

  credit_counter #(
    .CREDITS (CREDITS),
    .CNT_W   (CNT_W)
  ) u_credit_counter (
    .clk (clk),
    .rst (rst),
    .inc (credit_in),
    .dec (flit_valid),
    .cnt (credit_cnt),
    .err (credit_err)
  );

  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
  a_grant_in_sel : assert property (@(posedge clk) disable iff (!rst) (grant & ~xbar_sel) == '0);
  a_cnt_bound    : assert property (@(posedge clk) disable iff (!rst) credit_cnt <= CNT_W'(CREDITS));

endmodule

// File: tb/tb_credit_arbiter.sv
// Directed bench for credit_arbiter with a packet-level reference model
// compared every cycle, plus hand-computed checkpoints.
module tb_credit_arbiter;

  localparam int CREDITS = 4;
  localparam int CNT_W   = $clog2(CREDITS + 1);

  logic             clk;
  logic             rst;
  logic [4:0]       req;
  logic [4:0]       tail;
  logic             credit_in;
  logic [4:0]       grant;
  logic [4:0]       xbar_sel;
  logic             flit_valid;
  logic [CNT_W-1:0] credit_cnt;
  logic             credit_err;

  int errors = 0;
  int checks = 0;
  bit run    = 1'b0;

  credit_arbiter #(.CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .tail       (tail),
    .credit_in  (credit_in),
    .grant      (grant),
    .xbar_sel   (xbar_sel),
    .flit_valid (flit_valid),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet owner as a port number, credits as a plain integer.
  bit m_locked  = 1'b0;
  int m_owner   = 0;
  int m_rr      = 4;
  int m_credits = CREDITS;
  bit m_err     = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_locked  <= 1'b0;
      m_owner   <= 0;
      m_rr      <= 4;
      m_credits <= CREDITS;
      m_err     <= 1'b0;
    end else begin
      bit g;
      int win;
      g   = m_locked && req[m_owner[2:0]] && (m_credits > 0);
      win = -1;
      if (g && !credit_in) m_credits <= m_credits - 1;
      else if (credit_in && !g) begin
        if (m_credits == CREDITS) m_err <= 1'b1;
        else m_credits <= m_credits + 1;
      end
      if (m_locked) begin
        if (g && tail[m_owner[2:0]]) begin
          m_locked <= 1'b0;
          m_rr     <= (m_owner + 1) % 5;
        end
      end else begin
        for (int k = 0; k < 5; k++) begin
          int idx;
          idx = (m_rr + k) % 5;
          if (win < 0 && req[idx[2:0]]) win = idx;
        end
        if (win >= 0) begin
          m_locked <= 1'b1;
          m_owner  <= win;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] eg;
    logic [4:0] ex;
    if (run) begin
      eg = '0;
      ex = '0;
      if (m_locked) begin
        ex[m_owner[2:0]] = 1'b1;
        if (req[m_owner[2:0]] && m_credits > 0) eg[m_owner[2:0]] = 1'b1;
      end
      check("cmp_grant", int'(grant), int'(eg));
      check("cmp_xbar_sel", int'(xbar_sel), int'(ex));
      check("cmp_flit_valid", int'(flit_valid), int'(|eg));
      check("cmp_credit_cnt", int'(credit_cnt), m_credits);
      check("cmp_credit_err", int'(credit_err), int'(m_err));
    end
  end

  // Drive one cycle of inputs just after the edge, then return at the falling edge.
  task automatic cyc(input logic [4:0] r, input logic [4:0] t, input logic c);
    @(posedge clk);
    #1;
    req       = r;
    tail      = t;
    credit_in = c;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    req       = '0;
    tail      = '0;
    credit_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_credit_cnt", int'(credit_cnt), 4);
    check("rst_grant", int'(grant), 0);
    check("rst_xbar_sel", int'(xbar_sel), 0);
    check("rst_credit_err", int'(credit_err), 0);
    run = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;

    repeat (3) cyc(5'b00000, 5'b00000, 1'b0);
    check("idle_grant", int'(grant), 0);
    check("idle_xbar_sel", int'(xbar_sel), 0);

    cyc(5'b10001, 5'b10000, 1'b0);
    check("arb_latency_grant", int'(grant), 0);
    cyc(5'b10001, 5'b10000, 1'b0);
    check("prio_L_grant", int'(grant), 'b10000);
    check("prio_L_xbar_sel", int'(xbar_sel), 'b10000);
    check("prio_L_flit_valid", int'(flit_valid), 1);
    cyc(5'b10001, 5'b10000, 1'b1);
    check("bubble_grant", int'(grant), 0);
    check("bubble_xbar_sel", int'(xbar_sel), 0);

    cyc(5'b00001, 5'b00000, 1'b0);
    check("rr_N_grant", int'(grant), 'b00001);
    check("rr_N_credit_cnt", int'(credit_cnt), 4);
    repeat (3) begin
      cyc(5'b00001, 5'b00000, 1'b0);
      check("drain_grant", int'(grant), 'b00001);
    end
    cyc(5'b00001, 5'b00000, 1'b0);
    check("empty_grant", int'(grant), 0);
    check("empty_xbar_sel", int'(xbar_sel), 'b00001);
    check("empty_credit_cnt", int'(credit_cnt), 0);
    cyc(5'b00001, 5'b00000, 1'b0);
    cyc(5'b00001, 5'b00000, 1'b1);
    check("pulse_grant", int'(grant), 0);
    cyc(5'b00001, 5'b00000, 1'b0);
    check("one_credit_grant", int'(grant), 'b00001);
    check("one_credit_cnt", int'(credit_cnt), 1);
    cyc(5'b00001, 5'b00000, 1'b0);
    check("reblocked_grant", int'(grant), 0);

    cyc(5'b00000, 5'b00000, 1'b1);
    cyc(5'b00000, 5'b00000, 1'b1);
    check("hold_xbar_sel", int'(xbar_sel), 'b00001);
    cyc(5'b00001, 5'b00000, 1'b1);
    check("both_credit_cnt", int'(credit_cnt), 2);
    check("both_flit_valid", int'(flit_valid), 1);
    cyc(5'b00000, 5'b00000, 1'b0);
    check("both_after_cnt", int'(credit_cnt), 2);

    cyc(5'b00001, 5'b00001, 1'b0);
    check("tail_N_grant", int'(grant), 'b00001);
    repeat (3) cyc(5'b00000, 5'b00000, 1'b1);
    cyc(5'b00000, 5'b00000, 1'b1);
    check("full_credit_cnt", int'(credit_cnt), 4);
    cyc(5'b00000, 5'b00000, 1'b0);
    check("ovf_credit_err", int'(credit_err), 1);
    check("ovf_credit_cnt", int'(credit_cnt), 4);
    repeat (3) cyc(5'b00000, 5'b00000, 1'b0);
    check("ovf_sticky", int'(credit_err), 1);

    cyc(5'b00010, 5'b00000, 1'b0);
    cyc(5'b00010, 5'b00000, 1'b0);
    check("E_grant", int'(grant), 'b00010);
    repeat (3) begin
      cyc(5'b01000, 5'b01000, 1'b0);
      check("E_hold_xbar_sel", int'(xbar_sel), 'b00010);
      check("E_hold_grant", int'(grant), 0);
    end
    cyc(5'b01010, 5'b00000, 1'b0);
    check("E_resume_grant", int'(grant), 'b00010);

    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_grant", int'(grant), 0);
    check("async_rst_xbar_sel", int'(xbar_sel), 0);
    check("async_rst_credit_cnt", int'(credit_cnt), 4);
    check("async_rst_credit_err", int'(credit_err), 0);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    req  = 5'b10001;
    tail = 5'b00000;
    @(negedge clk);
    cyc(5'b10001, 5'b00000, 1'b0);
    check("post_rst_L_grant", int'(grant), 'b10000);
    repeat (2) cyc(5'b00000, 5'b00000, 1'b0);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
